calc_operand_sequencer: RTL and testbench

//  Upstream control stage for the 8-bit calculator's operand registers.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 43 ++++
 rtl/calc_operand_sequencer.sv | 112 +++++++++++
 tb/tb_calc_operand_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator operand sequencer: FSM states, display stage
// codes and opcode values.
package calc_pkg;

    typedef enum logic [2:0] {
        StIdleA,
        StLoadA,
        StWaitB,
        StLoadB,
        StWaitOp,
        StLoadOp,
        StStart,
        StWaitDone
    } state_t;

    localparam logic [1:0] STAGE_A    = 2'd0;
    localparam logic [1:0] STAGE_B    = 2'd1;
    localparam logic [1:0] STAGE_OP   = 2'd2;
    localparam logic [1:0] STAGE_CALC = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] r;
        r = STAGE_A;
        unique case (s)
            StIdleA, StLoadA:    r = STAGE_A;
            StWaitB, StLoadB:    r = STAGE_B;
            StWaitOp, StLoadOp:  r = STAGE_OP;
            StStart, StWaitDone: r = STAGE_CALC;
            default:             r = STAGE_A;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counter debounce; press is a one-cycle pulse on the
// rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, level_q, press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This sample is the last of the required run of differing samples.
                level_q <= ~level_q;
                press_q <= ~level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Operand entry sequencer: loads A, B and opcode from the switches on ENTER presses,
// then starts the ALU and waits for done or a timeout.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    input  logic       alu_done,
    output logic [7:0] data_bus,
    output logic       en_a,
    output logic       en_b,
    output logic       en_op,
    output logic       start,
    output logic       busy,
    output logic       err,
    output logic [1:0] stage
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          enter_press, clear_press;
    state_t        state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          clr_pend_q, clr_pend_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_enter),
        .press (enter_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .press (clear_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdleA;
            hold_q     <= '0;
            tcnt_q     <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tcnt_q     <= tcnt_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tcnt_d     = tcnt_q;
        clr_pend_d = clr_pend_q;
        err        = 1'b0;
        unique case (state_q)
            StIdleA, StWaitB, StWaitOp: begin
                if (clear_press) begin
                    state_d = StIdleA;
                end else if (enter_press) begin
                    hold_d = sw;
                    unique case (state_q)
                        StIdleA: state_d = StLoadA;
                        StWaitB: state_d = StLoadB;
                        default: state_d = StLoadOp;
                    endcase
                end
            end
            StLoadA:  state_d = clear_press ? StIdleA : StWaitB;
            StLoadB:  state_d = clear_press ? StIdleA : StWaitOp;
            StLoadOp: state_d = clear_press ? StIdleA : StStart;
            StStart: begin
                // A clear arriving here is deferred to the first WAIT_DONE cycle.
                clr_pend_d = clr_pend_q | clear_press;
                tcnt_d     = '0;
                state_d    = StWaitDone;
            end
            StWaitDone: begin
                tcnt_d = tcnt_q + TW'(1);
                if (alu_done || clear_press || clr_pend_q) begin
                    state_d    = StIdleA;
                    clr_pend_d = 1'b0;
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err        = 1'b1;
                    state_d    = StIdleA;
                    clr_pend_d = 1'b0;
                end
            end
            default: state_d = StIdleA;
        endcase
    end

    assign data_bus = hold_q;
    assign en_a     = (state_q == StLoadA);
    assign en_b     = (state_q == StLoadB);
    assign en_op    = (state_q == StLoadOp);
    assign start    = (state_q == StStart);
    assign busy     = (state_q == StStart) || (state_q == StWaitDone);
    assign stage    = stage_of(state_q);

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed and randomized checks of the operand sequencer against a simple
// expected-value model of button presses, loads and the ALU handshake.
module tb_calc_operand_sequencer;

    localparam int DB = 16;
    localparam int TO = 255;
    localparam int HOLD = DB + 6;

    logic       clk, rst, btn_enter, btn_clear, alu_done;
    logic [7:0] sw, data_bus;
    logic       en_a, en_b, en_op, start, busy, err;
    logic [1:0] stage;

    int total = 0;
    int bad = 0;
    int na = 0, nb = 0, nop = 0, nstart = 0, nerr = 0, nmulti = 0;
    logic [7:0] cap_a = '0, cap_b = '0, cap_op = '0;
    int ev_q[$];

    calc_operand_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .alu_done  (alu_done),
        .data_bus  (data_bus),
        .en_a      (en_a),
        .en_b      (en_b),
        .en_op     (en_op),
        .start     (start),
        .busy      (busy),
        .err       (err),
        .stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe load strobes and capture what the Reg8 registers would hold.
    always @(negedge clk) begin
        if (en_a)  begin na++;  cap_a  = data_bus; ev_q.push_back(1); end
        if (en_b)  begin nb++;  cap_b  = data_bus; ev_q.push_back(2); end
        if (en_op) begin nop++; cap_op = data_bus; ev_q.push_back(3); end
        if (start) begin nstart++; ev_q.push_back(4); end
        if (err)   begin nerr++; ev_q.push_back(5); end
        if (int'(en_a) + int'(en_b) + int'(en_op) > 1) nmulti++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return en_a;
            1: return en_b;
            2: return en_op;
            3: return start;
            default: return err;
        endcase
    endfunction

    // Returns the number of ticks until the selected output is seen high, or -1.
    task automatic wait_sig(input int sel, input int maxc, output int k);
        k = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick(1);
            if (sig(sel)) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic press_enter(input logic [7:0] v);
        sw = v;
        btn_enter = 1'b1;
        tick(HOLD);
        btn_enter = 1'b0;
        tick(HOLD);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        tick(HOLD);
        btn_clear = 1'b0;
        tick(HOLD);
    endtask

    initial begin
        int k, k2, base, n0, e0, s0;
        logic [7:0] va, vb, vo, vx;
        int dly;

        rst = 1'b1; sw = '0; btn_enter = 1'b0; btn_clear = 1'b0; alu_done = 1'b0;
        tick(3);
        chk("rst_outputs", {data_bus, en_a, en_b, en_op, start, busy, err, stage}, '0);
        rst = 1'b0;
        alu_done = 1'b1;
        tick(4);
        alu_done = 1'b0;
        chk("idle_done_ignored", {busy, stage}, '0);

        // T1: load latency and single en_a
        sw = 8'h2A;
        btn_enter = 1'b1;
        wait_sig(0, 40, k);
        chk("t1_latency", k, DB + 3);
        chk("t1_bus", data_bus, 8'h2A);
        chk("t1_stage_a", stage, 0);
        tick(1);
        chk("t1_en_a_1cyc", en_a, 0);
        chk("t1_stage_b", stage, 1);
        btn_enter = 1'b0;
        tick(HOLD);
        chk("t1_en_a_count", na, 1);

        // T5: simultaneous enter+clear in WAIT_OP
        vb = 8'($urandom);
        press_enter(vb);
        chk("t5_stage_op", stage, 2);
        n0 = nop;
        sw = ~vb;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick(HOLD);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(HOLD);
        chk("t5_no_en_op", nop - n0, 0);
        chk("t5_stage", stage, 0);
        chk("t5_bus_kept", data_bus, vb);

        // T2: full sequence with ALU done after 10 cycles
        base = ev_q.size();
        press_enter(8'h05);
        press_enter(8'h03);
        sw = 8'h01;
        btn_enter = 1'b1;
        wait_sig(3, 40, k);
        chk("t2_start", start, 1);
        chk("t2_busy_start", busy, 1);
        tick(1);
        chk("t2_start_1cyc", start, 0);
        chk("t2_busy_wait", busy, 1);
        tick(9);
        alu_done = 1'b1;
        tick(1);
        alu_done = 1'b0;
        chk("t2_busy_done", busy, 0);
        chk("t2_stage_done", stage, 0);
        btn_enter = 1'b0;
        tick(HOLD);
        chk("t2_regs", {cap_a, cap_b, cap_op}, 24'h050301);
        chk("t2_ev_count", ev_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk("t2_order", (base + i < ev_q.size()) ? ev_q[base + i] : -1, i + 1);

        // T3: bouncing enter yields one press
        n0 = na;
        sw = 8'h5C;
        for (int i = 0; i < 40; i++) begin
            btn_enter = ((i / 3) % 2) == 0;
            tick(1);
        end
        btn_enter = 1'b1;
        tick(HOLD);
        btn_enter = 1'b0;
        tick(HOLD);
        chk("t3_one_press", na - n0, 1);
        chk("t3_stage", stage, 1);
        press_clear();
        chk("t3_cleared", stage, 0);

        // T4: timeout
        e0 = nerr;
        press_enter(8'($urandom));
        press_enter(8'($urandom));
        sw = 8'($urandom);
        btn_enter = 1'b1;
        wait_sig(3, 40, k);
        wait_sig(4, TO + 20, k2);
        chk("t4_err_latency", k2, TO);
        chk("t4_busy_at_err", busy, 1);
        tick(1);
        chk("t4_after", {err, busy, stage}, '0);
        btn_enter = 1'b0;
        tick(HOLD);
        chk("t4_err_count", nerr - e0, 1);

        // T6: reset during LOAD_B
        va = 8'($urandom);
        press_enter(va);
        sw = 8'($urandom);
        btn_enter = 1'b1;
        wait_sig(1, 40, k);
        chk("t6_en_b_seen", k, DB + 3);
        rst = 1'b1;
        btn_enter = 1'b0;
        tick(1);
        chk("t6_outputs", {data_bus, en_a, en_b, en_op, start, busy, err, stage}, '0);
        rst = 1'b0;
        tick(HOLD);
        vx = 8'($urandom);
        press_enter(vx);
        chk("t6_restart_a", cap_a, vx);
        chk("t6_restart_stage", stage, 1);
        press_clear();

        // T7: clear landing in START is taken on the first WAIT_DONE cycle
        e0 = nerr;
        press_enter(8'($urandom));
        press_enter(8'($urandom));
        sw = 8'($urandom);
        btn_enter = 1'b1;
        tick(2);
        btn_clear = 1'b1;
        wait_sig(3, 40, k);
        chk("t7_start", start, 1);
        tick(1);
        chk("t7_wait_done", {busy, stage}, 3'b111);
        tick(1);
        chk("t7_aborted", {busy, stage, err}, '0);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(HOLD);
        chk("t7_no_err", nerr - e0, 0);

        // Randomized full sequences
        for (int it = 0; it < 5; it++) begin
            va = 8'($urandom);
            vb = 8'($urandom);
            vo = 8'($urandom);
            dly = int'($urandom_range(1, 40));
            e0 = nerr;
            s0 = nstart;
            press_enter(va);
            press_enter(vb);
            sw = vo;
            btn_enter = 1'b1;
            wait_sig(3, 40, k);
            tick(dly);
            chk("rnd_busy_wait", busy, 1);
            alu_done = 1'b1;
            tick(1);
            alu_done = 1'b0;
            btn_enter = 1'b0;
            tick(HOLD);
            chk("rnd_regs", {cap_a, cap_b, cap_op}, {va, vb, vo});
            chk("rnd_bus", data_bus, vo);
            chk("rnd_idle", {busy, stage}, '0);
            chk("rnd_starts", nstart - s0, 1);
            chk("rnd_no_err", nerr - e0, 0);
        end

        chk("one_hot_enables", nmulti, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
